// File: rtl/window_sum3x3.sv
// rtl/window_sum3x3.sv - 3x3 neighbourhood sum over a raster pixel stream
// Two line buffers feed a per-column sum; three column sums are added for each full window.
module window_sum3x3 #(
    parameter int PIXEL_WIDTH = 8,
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480
) (
    input  logic                   clk,
    input  logic                   arstn,
    input  logic [PIXEL_WIDTH-1:0] din_data,
    input  logic                   din_valid,
    output logic                   dout_valid,
    output logic [PIXEL_WIDTH+3:0] dout_data
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [PIXEL_WIDTH-1:0] lb0 [IMG_WIDTH];
    logic [PIXEL_WIDTH-1:0] lb1 [IMG_WIDTH];
    logic [PIXEL_WIDTH+1:0] colsum;
    logic [PIXEL_WIDTH+1:0] cs0, cs1, cs2;
    logic [PIXEL_WIDTH+3:0] winsum;
    logic                   v1;
    logic                   last_col;
    logic                   last_row;
    logic                   window_full;

    assign last_col    = (col == CW'(IMG_WIDTH - 1));
    assign last_row    = (row == RW'(IMG_HEIGHT - 1));
    assign window_full = (row >= RW'(2)) && (col >= CW'(2));

    assign colsum = {2'b00, din_data} + {2'b00, lb1[col]} + {2'b00, lb0[col]};
    assign winsum = {2'b00, cs0} + {2'b00, cs1} + {2'b00, cs2};

    // Framing is purely by beat count; there is no frame-start input.
    always_ff @(posedge clk) begin
        if (!arstn) begin
            col <= '0;
            row <= '0;
        end else if (din_valid) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line-buffer storage is not reset; unqualified windows never reach the output.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            lb0[col] <= lb1[col];
            lb1[col] <= din_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            cs0 <= '0;
            cs1 <= '0;
            cs2 <= '0;
            v1  <= 1'b0;
        end else begin
            v1 <= din_valid & window_full;
            if (din_valid) begin
                cs0 <= colsum;
                cs1 <= cs0;
                cs2 <= cs1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            dout_valid <= 1'b0;
            dout_data  <= '0;
        end else begin
            dout_valid <= v1;
            if (v1) begin
                dout_data <= winsum;
            end
        end
    end

endmodule
